// File: rtl/uncache_bus_agent.sv
// uncache_bus_agent: single-beat uncached load/store agent between the CPU
// memory stage and an AXI4 interconnect. One transaction outstanding at a time.
// Build option: define UNCACHE_WBUF_EN for a one-entry posted-write buffer
// (stores report data_ok right after acceptance; B drains in the background).
module uncache_bus_agent #(
    parameter int              ID_W   = 4,
    parameter logic [ID_W-1:0] BUS_ID = ID_W'(1)
) (
    input  logic            clk,
    input  logic            rst,
    // CPU side
    input  logic            req,
    input  logic            wr,
    input  logic [1:0]      size,
    input  logic [31:0]     addr,
    input  logic [31:0]     wdata,
    input  logic [3:0]      wstrb,
    output logic            addr_ok,
    output logic            data_ok,
    output logic [31:0]     rdata,
    // AXI read address
    output logic [ID_W-1:0] arid,
    output logic [31:0]     araddr,
    output logic [7:0]      arlen,
    output logic [2:0]      arsize,
    output logic            arvalid,
    input  logic            arready,
    // AXI read data
    input  logic [ID_W-1:0] rid,
    input  logic [31:0]     rdata_axi,
    input  logic            rvalid,
    output logic            rready,
    // AXI write address
    output logic [ID_W-1:0] awid,
    output logic [31:0]     awaddr,
    output logic [7:0]      awlen,
    output logic [2:0]      awsize,
    output logic            awvalid,
    input  logic            awready,
    // AXI write data
    output logic [31:0]     wdata_axi,
    output logic [3:0]      wstrb_axi,
    output logic            wlast,
    output logic            wvalid,
    input  logic            wready,
    // AXI write response
    input  logic            bvalid,
    output logic            bready
);

`ifdef UNCACHE_WBUF_EN
    localparam bit WBUF = 1'b1;
`else
    localparam bit WBUF = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;
    logic        data_ok_q, data_ok_d;
    logic [31:0] rdata_q, rdata_d;
    logic        aw_done, w_done;

    // Only one transaction is ever in flight, so the response ID carries no information.
    logic unused_rid;
    assign unused_rid = &{1'b0, rid};

    // Next-state and handshake logic; the buffered store keeps the FSM busy, so
    // while it drains every new request (load or store) is held off.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        rdata_d   = rdata_q;
        data_ok_d = 1'b0;
        addr_ok   = 1'b0;
        aw_done   = 1'b0;
        w_done    = 1'b0;
        case (state_q)
            IDLE: begin
                addr_ok = req;
                if (req) begin
                    addr_d  = addr;
                    size_d  = size;
                    wdata_d = wdata;
                    wstrb_d = wstrb;
                    if (wr) begin
                        state_d   = WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        data_ok_d = WBUF;
                    end else begin
                        state_d   = RD_ADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            RD_ADDR: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (rvalid) begin
                    rdata_d   = rdata_axi;
                    rready_d  = 1'b0;
                    data_ok_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            WR_REQ: begin
                // AW and W retire independently; leave once both channels are done.
                aw_done = !awvalid_q || awready;
                w_done  = !wvalid_q || wready;
                if (awvalid_q && awready) awvalid_d = 1'b0;
                if (wvalid_q && wready)   wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bvalid) begin
                    bready_d  = 1'b0;
                    data_ok_d = !WBUF;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset; reset drops any transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            size_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            data_ok_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            data_ok_q <= data_ok_d;
            rdata_q   <= rdata_d;
        end
    end

    assign data_ok   = data_ok_q;
    assign rdata     = rdata_q;
    assign arid      = BUS_ID;
    assign araddr    = addr_q;
    assign arlen     = 8'd0;
    assign arsize    = {1'b0, size_q};
    assign arvalid   = arvalid_q;
    assign rready    = rready_q;
    assign awid      = BUS_ID;
    assign awaddr    = addr_q;
    assign awlen     = 8'd0;
    assign awsize    = {1'b0, size_q};
    assign awvalid   = awvalid_q;
    assign wdata_axi = wdata_q;
    assign wstrb_axi = wstrb_q;
    assign wlast     = 1'b1;
    assign wvalid    = wvalid_q;
    assign bready    = bready_q;

endmodule

// File: tb/tb_uncache_bus_agent.sv
// Bench for uncache_bus_agent: an in-bench AXI slave with per-channel wait
// counts, and a queue of expected completions popped on each data_ok.
module tb_uncache_bus_agent;
    localparam logic [3:0] BUS_ID = 4'h1;

    logic        clk = 1'b0;
    logic        rst, req, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;
    logic [3:0]  arid, rid, awid;
    logic [31:0] araddr, rdata_axi, awaddr, wdata_axi;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic        arvalid, arready, rvalid, rready, awvalid, awready;
    logic [3:0]  wstrb_axi;
    logic        wlast, wvalid, wready, bvalid, bready;

    uncache_bus_agent #(.ID_W(4), .BUS_ID(BUS_ID)) dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .addr(addr),
        .wdata(wdata), .wstrb(wstrb), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arvalid(arvalid),
        .arready(arready), .rid(rid), .rdata_axi(rdata_axi), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awvalid(awvalid),
        .awready(awready), .wdata_axi(wdata_axi), .wstrb_axi(wstrb_axi), .wlast(wlast),
        .wvalid(wvalid), .wready(wready), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    typedef struct {logic is_load; logic [31:0] data;} exp_t;
    exp_t exp_q[$];
    exp_t e;

    int n_pass = 0, n_total = 0;
    // slave knobs and state
    int ar_delay = 0, aw_delay = 0, w_delay = 0;
    int ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
    logic [31:0] rd_val = '0;
    bit r_stall = 0, r_pend = 0, aw_got = 0, w_got = 0, last_b_hs = 0;

    task automatic slave_reset();
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        rdata_axi = '0; ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
        r_pend = 0; aw_got = 0; w_got = 0; last_b_hs = 0;
    endtask

    // One clock: note handshakes before the edge, then update slave outputs 1ns after it.
    task automatic tick();
        bit ar_hs, r_hs, aw_hs, w_hs, b_hs;
        ar_hs = arvalid && arready; r_hs = rvalid && rready;
        aw_hs = awvalid && awready; w_hs = wvalid && wready; b_hs = bvalid && bready;
        @(posedge clk); #1;
        if (arvalid !== 1'b1) begin ar_cnt = 0; arready = 0; end
        else begin arready = (ar_cnt >= ar_delay); ar_cnt++; end
        if (awvalid !== 1'b1) begin aw_cnt = 0; awready = 0; end
        else begin awready = (aw_cnt >= aw_delay); aw_cnt++; end
        if (wvalid !== 1'b1) begin w_cnt = 0; wready = 0; end
        else begin wready = (w_cnt >= w_delay); w_cnt++; end
        if (r_hs) rvalid = 0;
        if (ar_hs) r_pend = 1;
        if (r_pend && !r_stall) begin rvalid = 1; rdata_axi = rd_val; r_pend = 0; end
        if (b_hs) bvalid = 0;
        if (aw_hs) aw_got = 1;
        if (w_hs) w_got = 1;
        if (aw_got && w_got) begin bvalid = 1; aw_got = 0; w_got = 0; end
        last_b_hs = b_hs;
    endtask

    task automatic drive_req(input logic w, input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] s);
        req = 1; wr = w; size = sz; addr = a; wdata = d; wstrb = s;
    endtask

    task automatic clear_req();
        req = 0; wr = 0;
    endtask

    task automatic test_reset();
        rst = 1; clear_req(); size = 0; addr = 0; wdata = 0; wstrb = 0; rid = BUS_ID;
        slave_reset();
        tick(); tick(); slave_reset();
        n_total++; if ({arvalid, awvalid, wvalid, rready, bready, data_ok} !== 6'b0)
            $display("FAIL reset_valids: got %b want 000000", {arvalid, awvalid, wvalid, rready, bready, data_ok}); else n_pass++;
        n_total++; if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", rdata); else n_pass++;
        n_total++; if (araddr !== 32'h0) $display("FAIL reset_araddr: got %h want 0", araddr); else n_pass++;
        n_total++; if ({arlen, awlen, wlast} !== 17'h1) $display("FAIL const_len_last: got %h want 00001", {arlen, awlen, wlast}); else n_pass++;
        n_total++; if ({arid, awid} !== {BUS_ID, BUS_ID}) $display("FAIL const_ids: got %h want 11", {arid, awid}); else n_pass++;
        rst = 0;
        tick();
    endtask

    task automatic test_load();
        int lat;
        ar_delay = 0; rd_val = 32'hDEAD_BEEF;
        drive_req(0, 2'd2, 32'h1FAF_F020, 32'h0, 4'h0); #1;
        n_total++; if (addr_ok !== 1'b1) $display("FAIL load_addr_ok: got %b want 1", addr_ok); else n_pass++;
        exp_q.push_back('{1'b1, 32'hDEAD_BEEF});
        tick(); clear_req();
        n_total++; if ({arvalid, araddr} !== {1'b1, 32'h1FAF_F020}) $display("FAIL load_ar: got %b/%h want 1/1faff020", arvalid, araddr); else n_pass++;
        n_total++; if ({arsize, arlen} !== {3'd2, 8'd0}) $display("FAIL load_arsize_len: got %0d/%0d want 2/0", arsize, arlen); else n_pass++;
        lat = 1;
        while (data_ok !== 1'b1 && lat < 20) begin tick(); lat++; end
        n_total++; if (lat !== 3) $display("FAIL load_latency: got %0d want 3", lat); else n_pass++;
        e = exp_q.pop_front();
        n_total++; if (rdata !== e.data) $display("FAIL load_rdata: got %h want %h", rdata, e.data); else n_pass++;
        tick();
        n_total++; if (data_ok !== 1'b0) $display("FAIL load_pulse_width: got %b want 0", data_ok); else n_pass++;
    endtask

    task automatic test_backpressure();
        int ar_cyc, bad_addr, bad_aok, early, lat;
        ar_delay = 10; rd_val = 32'h1234_5678;
        drive_req(0, 2'd2, 32'h1FAF_F040, 32'h0, 4'h0); #1;
        n_total++; if (addr_ok !== 1'b1) $display("FAIL bp_addr_ok: got %b want 1", addr_ok); else n_pass++;
        exp_q.push_back('{1'b1, 32'h1234_5678});
        tick();
        drive_req(0, 2'd2, 32'h1FAF_F080, 32'h0, 4'h0); #1;
        ar_cyc = 0; bad_addr = 0; bad_aok = 0; early = 0;
        while (arvalid === 1'b1 && ar_cyc < 40) begin
            ar_cyc++;
            if (araddr !== 32'h1FAF_F040) bad_addr++;
            if (addr_ok !== 1'b0) bad_aok++;
            if (data_ok !== 1'b0) early++;
            tick();
        end
        clear_req();
        n_total++; if (ar_cyc !== 11) $display("FAIL bp_arvalid_cycles: got %0d want 11", ar_cyc); else n_pass++;
        n_total++; if (bad_addr !== 0) $display("FAIL bp_araddr_stable: got %0d changes want 0", bad_addr); else n_pass++;
        n_total++; if (bad_aok !== 0) $display("FAIL bp_second_addr_ok: got %0d want 0", bad_aok); else n_pass++;
        n_total++; if (early !== 0 || data_ok !== 1'b0) $display("FAIL bp_early_data_ok: got %0d/%b want 0/0", early, data_ok); else n_pass++;
        lat = 0;
        while (data_ok !== 1'b1 && lat < 20) begin tick(); lat++; end
        e = exp_q.pop_front();
        n_total++; if (data_ok !== 1'b1 || rdata !== e.data) $display("FAIL bp_rdata: got %b/%h want 1/%h", data_ok, rdata, e.data); else n_pass++;
        ar_delay = 0;
        tick();
    endtask

    task automatic test_reset_mid_read();
        int cnt;
        r_stall = 1;
        drive_req(0, 2'd2, 32'h1FAF_F030, 32'h0, 4'h0); #1;
        exp_q.push_back('{1'b1, 32'h0});
        tick(); clear_req(); tick();
        n_total++; if (rready !== 1'b1) $display("FAIL rst_in_rd_data: got rready %b want 1", rready); else n_pass++;
        rst = 1; tick(); rst = 0;
        slave_reset(); r_stall = 0; exp_q.delete();
        n_total++; if ({arvalid, awvalid, wvalid, rready, bready, data_ok} !== 6'b0)
            $display("FAIL rst_mid_valids: got %b want 000000", {arvalid, awvalid, wvalid, rready, bready, data_ok}); else n_pass++;
        n_total++; if (rdata !== 32'h0) $display("FAIL rst_mid_rdata: got %h want 0", rdata); else n_pass++;
        req = 1; #1;
        n_total++; if (addr_ok !== 1'b1) $display("FAIL rst_mid_idle: got addr_ok %b want 1", addr_ok); else n_pass++;
        req = 0; #1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin tick(); if (data_ok !== 1'b0) cnt++; end
        n_total++; if (cnt !== 0) $display("FAIL rst_mid_no_data_ok: got %0d pulses want 0", cnt); else n_pass++;
    endtask

`ifndef UNCACHE_WBUF_EN
    task automatic test_store_w_first();
        int lat, aw_cyc, w_cyc;
        bit saw_b;
        aw_delay = 3; w_delay = 0;
        drive_req(1, 2'd0, 32'h1FAF_F000, 32'h0000_00FF, 4'b0001); #1;
        n_total++; if (addr_ok !== 1'b1) $display("FAIL st_addr_ok: got %b want 1", addr_ok); else n_pass++;
        exp_q.push_back('{1'b0, 32'h0});
        tick(); clear_req();
        n_total++; if ({awaddr, wdata_axi, wstrb_axi} !== {32'h1FAF_F000, 32'h0000_00FF, 4'b0001})
            $display("FAIL st_aw_w_fields: got %h/%h/%b want 1faff000/000000ff/0001", awaddr, wdata_axi, wstrb_axi); else n_pass++;
        n_total++; if ({awsize, awlen, wlast} !== {3'd0, 8'd0, 1'b1}) $display("FAIL st_awsize_len_last: got %0d/%0d/%b want 0/0/1", awsize, awlen, wlast); else n_pass++;
        lat = 1; aw_cyc = 0; w_cyc = 0; saw_b = 0;
        while (data_ok !== 1'b1 && lat < 40) begin
            if (awvalid === 1'b1) aw_cyc++;
            if (wvalid === 1'b1) w_cyc++;
            if (bready === 1'b1) saw_b = 1;
            tick(); lat++;
        end
        n_total++; if (w_cyc !== 1) $display("FAIL st_wvalid_cycles: got %0d want 1", w_cyc); else n_pass++;
        n_total++; if (aw_cyc !== 4) $display("FAIL st_awvalid_cycles: got %0d want 4", aw_cyc); else n_pass++;
        n_total++; if (saw_b !== 1'b1) $display("FAIL st_bready_seen: got %b want 1", saw_b); else n_pass++;
        n_total++; if (lat !== 6) $display("FAIL st_latency: got %0d want 6", lat); else n_pass++;
        e = exp_q.pop_front();
        n_total++; if (e.is_load !== 1'b0) $display("FAIL st_completion_kind: got load want store"); else n_pass++;
        tick();
        n_total++; if (data_ok !== 1'b0) $display("FAIL st_pulse_width: got %b want 0", data_ok); else n_pass++;
        aw_delay = 0;
    endtask

    task automatic test_back_to_back();
        int lat;
        rd_val = 32'hCAFE_0001;
        drive_req(0, 2'd2, 32'h1FAF_F010, 32'h0, 4'h0); #1;
        exp_q.push_back('{1'b1, 32'hCAFE_0001});
        tick(); clear_req();
        lat = 1;
        while (data_ok !== 1'b1 && lat < 20) begin tick(); lat++; end
        e = exp_q.pop_front();
        n_total++; if (rdata !== e.data) $display("FAIL b2b_rdata: got %h want %h", rdata, e.data); else n_pass++;
        drive_req(1, 2'd2, 32'h1FAF_F014, 32'hA5A5_5A5A, 4'hF); #1;
        n_total++; if ({addr_ok, data_ok} !== 2'b11) $display("FAIL b2b_addr_ok: got %b want 11", {addr_ok, data_ok}); else n_pass++;
        exp_q.push_back('{1'b0, 32'h0});
        tick(); clear_req();
        n_total++; if ({awvalid, wvalid, awaddr} !== {2'b11, 32'h1FAF_F014}) $display("FAIL b2b_no_bubble: got %b%b/%h want 11/1faff014", awvalid, wvalid, awaddr); else n_pass++;
        lat = 1;
        while (data_ok !== 1'b1 && lat < 20) begin tick(); lat++; end
        n_total++; if (lat !== 3) $display("FAIL b2b_store_latency: got %0d want 3", lat); else n_pass++;
        e = exp_q.pop_front();
        n_total++; if (e.is_load !== 1'b0) $display("FAIL b2b_completion_kind: got load want store"); else n_pass++;
        tick();
    endtask
`else
    task automatic test_wbuf();
        int cyc, b_at, extra, lat;
        aw_delay = 2; w_delay = 0; rd_val = 32'h0BAD_F00D;
        // store then load
        drive_req(1, 2'd2, 32'h1FAF_F000, 32'h11, 4'hF); #1;
        exp_q.push_back('{1'b0, 32'h0});
        tick(); clear_req();
        e = exp_q.pop_front();
        n_total++; if (data_ok !== 1'b1 || e.is_load !== 1'b0) $display("FAIL wb_posted_data_ok: got %b want 1", data_ok); else n_pass++;
        drive_req(0, 2'd2, 32'h1FAF_F020, 32'h0, 4'h0); #1;
        cyc = 0; b_at = -1; extra = 0;
        while (addr_ok !== 1'b1 && cyc < 40) begin
            tick(); cyc++;
            if (last_b_hs) b_at = cyc;
            if (data_ok !== 1'b0) extra++;
        end
        n_total++; if (cyc !== 4 || b_at !== cyc) $display("FAIL wb_load_held: got %0d (b at %0d) want 4 (b at 4)", cyc, b_at); else n_pass++;
        n_total++; if (extra !== 0) $display("FAIL wb_extra_data_ok: got %0d want 0", extra); else n_pass++;
        exp_q.push_back('{1'b1, 32'h0BAD_F00D});
        tick(); clear_req();
        lat = 1;
        while (data_ok !== 1'b1 && lat < 20) begin tick(); lat++; end
        e = exp_q.pop_front();
        n_total++; if (lat !== 3 || rdata !== e.data) $display("FAIL wb_load_rdata: got %0d/%h want 3/%h", lat, rdata, e.data); else n_pass++;
        tick();
        // two stores
        drive_req(1, 2'd2, 32'h1FAF_F100, 32'h22, 4'hF); #1;
        tick(); clear_req();
        n_total++; if (data_ok !== 1'b1) $display("FAIL wb_store1_data_ok: got %b want 1", data_ok); else n_pass++;
        drive_req(1, 2'd2, 32'h1FAF_F104, 32'h33, 4'hF); #1;
        cyc = 0; b_at = -1;
        while (addr_ok !== 1'b1 && cyc < 40) begin
            tick(); cyc++;
            if (last_b_hs) b_at = cyc;
        end
        n_total++; if (cyc !== 4 || b_at !== cyc) $display("FAIL wb_store2_held: got %0d (b at %0d) want 4 (b at 4)", cyc, b_at); else n_pass++;
        tick(); clear_req();
        n_total++; if ({data_ok, awaddr} !== {1'b1, 32'h1FAF_F104}) $display("FAIL wb_store2_posted: got %b/%h want 1/1faff104", data_ok, awaddr); else n_pass++;
        for (int i = 0; i < 8; i++) tick();
        aw_delay = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_backpressure();
`ifndef UNCACHE_WBUF_EN
        test_store_w_first();
        test_back_to_back();
`else
        test_wbuf();
`endif
        test_reset_mid_read();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
